// File: rtl/global_defs.sv
// Shared MPU definitions: matrix geometry, element format, register-file
// addressing and the load sequencer state type.
package global_defs;

  // Element format and matrix geometry
  localparam int FP               = 32;
  localparam int M                = 4;
  localparam int N                = 4;
  localparam int MBITS            = $clog2(M);
  localparam int NBITS            = $clog2(N);
  localparam int MATRIX_REGISTERS = 8;
  localparam int MATRIX_REG_SIZE  = $clog2(MATRIX_REGISTERS);

  // Default idle limit for an optional load abort
  localparam int MPU_LOAD_TIMEOUT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // True when (m, n) addresses the last element of a row-major matrix walk
  function automatic logic is_last_elem(input logic [MBITS:0] m, input logic [NBITS:0] n);
    return (m == (MBITS+1)'(M-1)) && (n == (NBITS+1)'(N-1));
  endfunction

endpackage

// File: rtl/mpu_load_sequencer.sv
// mpu_load_sequencer: streams one M x N matrix, element by element in
// row-major order, into a register of mpu_register_file.
//
// Optional feature macro: MPU_LOAD_TIMEOUT_EN
//   defined     -> a LOAD that sees TIMEOUT_CYCLES cycles without an element
//                  handshake is aborted with a one-cycle load_err pulse.
//   not defined -> LOAD waits indefinitely, load_err is tied low.
//
// Handshakes: a request transfers on a cycle where load_req && load_ack; an
// element transfers on a cycle where elem_valid && elem_ready. Neither
// handshake has any effect while its ack/ready is low; the upstream side
// must hold its request/data stable until the handshake completes.
module mpu_load_sequencer
  import global_defs::*;
#(
  parameter int TIMEOUT_CYCLES = MPU_LOAD_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic [MATRIX_REG_SIZE-1:0] load_addr,
  output logic                       load_ack,
  input  logic                       elem_valid,
  input  logic [FP-1:0]              elem_data,
  output logic                       elem_ready,
  output logic                       write_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
  output logic [FP-1:0]              reg_element_in,
  output logic [MBITS:0]             reg_m_in,
  output logic [NBITS:0]             reg_n_in,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_err,
  output load_state_t                dbg_state
);

  load_state_t                state, state_next;
  logic [MATRIX_REG_SIZE-1:0] addr_q;
  logic [MBITS:0]             m_cnt;
  logic [NBITS:0]             n_cnt;
  logic                       elem_hs;
  logic                       last_elem;
  logic                       timeout;

  // Status decoded straight from state
  assign load_ack   = (state == IDLE);
  assign elem_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign elem_hs    = elem_valid && elem_ready;
  assign last_elem  = is_last_elem(m_cnt, n_cnt);

`ifdef MPU_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Idle cycles since the last element handshake while in LOAD
  always_ff @(posedge clk) begin
    if (!rst || state != LOAD || elem_hs) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + 1'b1;
  end

  // Abort in the cycle that completes TIMEOUT_CYCLES idle cycles
  assign timeout = (state == LOAD) && !elem_hs && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  assign load_err = timeout;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (load_req) state_next = LOAD;
      LOAD: begin
        if (elem_hs && last_elem) state_next = DONE;
        else if (timeout)         state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Target register latch and row/column walk; the column wraps into the row,
  // and both return to 0 after the last element so they never pass M-1 / N-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      m_cnt  <= '0;
      n_cnt  <= '0;
    end else if (state == IDLE && load_req) begin
      addr_q <= load_addr;
      m_cnt  <= '0;
      n_cnt  <= '0;
    end else if (elem_hs) begin
      if (n_cnt == (NBITS+1)'(N-1)) begin
        n_cnt <= '0;
        m_cnt <= last_elem ? '0 : m_cnt + 1'b1;
      end else begin
        n_cnt <= n_cnt + 1'b1;
      end
    end
  end

  // Registered write port: strobe one cycle after each handshake, data holds
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_en       <= 1'b0;
      load_done      <= 1'b0;
      reg_load_addr  <= '0;
      reg_element_in <= '0;
      reg_m_in       <= '0;
      reg_n_in       <= '0;
    end else begin
      write_en  <= elem_hs;
      load_done <= elem_hs && last_elem;
      if (elem_hs) begin
        reg_load_addr  <= addr_q;
        reg_element_in <= elem_data;
        reg_m_in       <= m_cnt;
        reg_n_in       <= n_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// Bench for mpu_load_sequencer (M=4, N=4, FP=32). Build with
// MPU_LOAD_TIMEOUT_EN defined to also exercise the timeout abort.
module tb_mpu_load_sequencer;
  import global_defs::*;

`ifdef MPU_LOAD_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 256;
`endif

  // Expected write: {addr[2:0], m[2:0], n[2:0], data[31:0], done}
  localparam int W = 42;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                       load_req = 1'b0;
  logic [MATRIX_REG_SIZE-1:0] load_addr = '0;
  logic                       load_ack;
  logic                       elem_valid = 1'b0;
  logic [FP-1:0]              elem_data = '0;
  logic                       elem_ready;
  logic                       write_en;
  logic [MATRIX_REG_SIZE-1:0] reg_load_addr;
  logic [FP-1:0]              reg_element_in;
  logic [MBITS:0]             reg_m_in;
  logic [NBITS:0]             reg_n_in;
  logic                       busy;
  logic                       load_done;
  logic                       load_err;
  load_state_t                dbg_state;

  mpu_load_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_req       (load_req),
    .load_addr      (load_addr),
    .load_ack       (load_ack),
    .elem_valid     (elem_valid),
    .elem_data      (elem_data),
    .elem_ready     (elem_ready),
    .write_en       (write_en),
    .reg_load_addr  (reg_load_addr),
    .reg_element_in (reg_element_in),
    .reg_m_in       (reg_m_in),
    .reg_n_in       (reg_n_in),
    .busy           (busy),
    .load_done      (load_done),
    .load_err       (load_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [31:0]  rf [8][4][4];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (write_en) begin
      if (exp_q.size() == 0) begin
        check("write_unexpected", 64'(write_en), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(reg_load_addr),  64'(mon_e[41:39]));
        check("wr_m",    64'(reg_m_in),       64'(mon_e[38:36]));
        check("wr_n",    64'(reg_n_in),       64'(mon_e[35:33]));
        check("wr_data", 64'(reg_element_in), 64'(mon_e[32:1]));
        check("wr_done", 64'(load_done),      64'(mon_e[0]));
        rf[int'(reg_load_addr)][int'(reg_m_in[1:0])][int'(reg_n_in[1:0])] = reg_element_in;
      end
    end else if (load_done) begin
      check("done_without_write", 64'(load_done), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request and complete its handshake; leaves load_req low
  task automatic request(input logic [2:0] addr);
    int bound = 0;
    load_req  = 1'b1;
    load_addr = addr;
    while (!load_ack && bound < 100) begin
      @(posedge clk); #1;
      bound++;
    end
    if (!load_ack) check("ack_wait", 64'(load_ack), 64'd1);
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Stream count elements starting at element 0, gap idle cycles between them
  task automatic send_elems(input logic [2:0] addr, input int count, input int gap,
                            input logic [31:0] base);
    logic [31:0] d;
    int bound;
    for (int i = 0; i < count; i++) begin
      if (i > 0 && gap > 0) begin
        elem_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      d          = base + 32'(i);
      elem_valid = 1'b1;
      elem_data  = d;
      bound      = 0;
      while (!elem_ready && bound < 100) begin
        @(posedge clk); #1;
        bound++;
      end
      if (!elem_ready) check("ready_wait", 64'(elem_ready), 64'd1);
      exp_q.push_back({addr, 3'(i / 4), 3'(i % 4), d, (i == 15)});
      @(posedge clk); #1;
    end
    elem_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) begin @(posedge clk); #1; end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset for two cycles, check every output
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_en",   64'(write_en),       64'd0);
    check("rst_addr",       64'(reg_load_addr),  64'd0);
    check("rst_elem",       64'(reg_element_in), 64'd0);
    check("rst_m",          64'(reg_m_in),       64'd0);
    check("rst_n",          64'(reg_n_in),       64'd0);
    check("rst_busy",       64'(busy),           64'd0);
    check("rst_load_done",  64'(load_done),      64'd0);
    check("rst_load_err",   64'(load_err),       64'd0);
    check("rst_elem_ready", 64'(elem_ready),     64'd0);
    check("rst_load_ack",   64'(load_ack),       64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load into register 3, then read the model file back
    request(3'd3);
    check("load_busy", 64'(busy), 64'd1);
    send_elems(3'd3, 16, 0, 32'h3F80_0000);
    check("done_state_ack", 64'(load_ack), 64'd0);
    @(posedge clk); #1;
    check("ack_after_done", 64'(load_ack), 64'd1);
    drain("drain_b2b");
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++)
        check("rf_readback", 64'(rf[3][m][n]), 64'(32'h3F80_0000 + 32'(m * 4 + n)));

    // Same load with a bubble between every element
    request(3'd3);
    send_elems(3'd3, 16, 1, $urandom);
    drain("drain_gap");

    // A second request held during LOAD is ignored, then acked after DONE
    request(3'd5);
    load_req  = 1'b1;
    load_addr = 3'd6;
    send_elems(3'd5, 16, $urandom_range(0, 2), $urandom);
    check("held_req_done_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("held_req_ack", 64'(load_ack), 64'd1);
    @(posedge clk); #1;
    check("held_req_taken", 64'(load_ack), 64'd0);
    load_req = 1'b0;
    send_elems(3'd6, 16, 0, $urandom);
    drain("drain_held");

    // Reset after 5 elements abandons the load; the next starts at (0,0)
    request(3'd2);
    send_elems(3'd2, 5, 0, $urandom);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_mid_ack",   64'(load_ack),  64'd1);
    check("rst_mid_busy",  64'(busy),      64'd0);
    check("rst_mid_done",  64'(load_done), 64'd0);
    drain("drain_rst");
    request(3'd2);
    send_elems(3'd2, 16, 0, $urandom);
    drain("drain_after_rst");

`ifdef MPU_LOAD_TIMEOUT_EN
    // Stall after 2 elements: abort pulse 8 cycles after the last handshake
    begin
      int k = 0;
      request(3'd1);
      send_elems(3'd1, 2, 0, $urandom);
      // Now in the first cycle after the last handshake
      while (!load_err && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      check("timeout_delay", 64'(k), 64'd7);
      check("timeout_no_done", 64'(load_done), 64'd0);
      @(posedge clk); #1;
      check("timeout_ack", 64'(load_ack), 64'd1);
      check("timeout_err_pulse", 64'(load_err), 64'd0);
      drain("drain_timeout");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
